// File: rtl/osc_meas_pkg.sv
// rtl/osc_meas_pkg.sv - shared constants and FSM state type for the oscillator edge counter
package osc_meas_pkg;

    localparam int COUNT_W_DEF     = 16;
    localparam int GATE_W_DEF      = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } meas_state_e;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - multi-flop synchroniser followed by a one-cycle rising-edge detector
module edge_sync
    import osc_meas_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic wb_clk_i,
    input  logic wb_rst_n_i,
    input  logic async_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Combinational pulse so the counter adds the edge on the very next clock.
    assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/osc_edge_counter.sv
// rtl/osc_edge_counter.sv - gated rising-edge counter for an asynchronous oscillator input
module osc_edge_counter
    import osc_meas_pkg::*;
#(
    parameter int COUNT_W     = COUNT_W_DEF,
    parameter int GATE_W      = GATE_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               osc_i,
    input  logic               start_i,
    input  logic [GATE_W-1:0]  gate_i,
    output logic [COUNT_W-1:0] count_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               overflow_o
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [GATE_W-1:0]  GATE_ONE  = {{(GATE_W-1){1'b0}}, 1'b1};

    meas_state_e       state_q;
    logic [GATE_W-1:0] gate_q;
    logic              osc_edge;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_n_i(wb_rst_n_i),
        .async_i   (osc_i),
        .edge_o    (osc_edge)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= ST_IDLE;
            gate_q     <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        gate_q     <= gate_i;
                        count_o    <= '0;
                        overflow_o <= 1'b0;
                        busy_o     <= 1'b1;
                        if (gate_i == '0) begin
                            state_q <= ST_DONE;
                            done_o  <= 1'b1;
                        end else begin
                            state_q <= ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    gate_q <= gate_q - GATE_ONE;
                    if (osc_edge) begin
                        if (count_o == COUNT_MAX) begin
                            overflow_o <= 1'b1;
                        end else begin
                            count_o <= count_o + COUNT_ONE;
                        end
                    end
                    // Leaving on gate==1 makes the window exactly gate_i sampled cycles.
                    if (gate_q == GATE_ONE) begin
                        state_q <= ST_DONE;
                        done_o  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osc_edge_counter.sv
// tb/tb_osc_edge_counter.sv - scoreboard bench for osc_edge_counter
`timescale 1ns/1ps
module tb_osc_edge_counter;

    typedef struct {
        int count;
        int ovf;
        int cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        osc = 1'b0;
    logic        start = 1'b0;
    logic [15:0] gate = '0;
    logic [15:0] count;
    logic        busy, done, ovf;

    logic        start_s = 1'b0;
    logic [15:0] gate_s = '0;
    logic [3:0]  count_s;
    logic        busy_s, done_s, ovf_s;

    exp_t q_big[$];
    exp_t q_small[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   osc_period = 0;
    int   osc_ph = 0;

    osc_edge_counter u_dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .osc_i     (osc),
        .start_i   (start),
        .gate_i    (gate),
        .count_o   (count),
        .busy_o    (busy),
        .done_o    (done),
        .overflow_o(ovf)
    );

    osc_edge_counter #(.COUNT_W(4)) u_small (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .osc_i     (osc),
        .start_i   (start_s),
        .gate_i    (gate_s),
        .count_o   (count_s),
        .busy_o    (busy_s),
        .done_o    (done_s),
        .overflow_o(ovf_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (osc_period != 0) begin
            osc_ph = (osc_ph + 1) % osc_period;
            osc    = (osc_ph < osc_period / 2);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (q_big.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done_big actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                mon_e = q_big.pop_front();
                check("count_big", int'(count), mon_e.count);
                check("overflow_big", int'(ovf), mon_e.ovf);
                check("done_cycle_big", cyc, mon_e.cyc);
            end
        end
        if (done_s) begin
            if (q_small.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done_small actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                mon_e = q_small.pop_front();
                check("count_small", int'(count_s), mon_e.count);
                check("overflow_small", int'(ovf_s), mon_e.ovf);
                check("done_cycle_small", cyc, mon_e.cyc);
            end
        end
    end

    // Called just after a falling edge; the start is sampled on the next rising edge.
    task automatic do_start(input int g, input int exp_count, input int exp_ovf, input bit push);
        exp_t e;
        e.count = exp_count;
        e.ovf   = exp_ovf;
        e.cyc   = cyc + g + 1;
        if (push) q_big.push_back(e);
        gate  = 16'(g);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q_big.size() + q_small.size()) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, q_big.size() + q_small.size(), 0);
        q_big.delete();
        q_small.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_count", int'(count), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_overflow", int'(ovf), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // One edge every 4 clocks over a 100-cycle window.
        osc_period = 4;
        repeat (10) @(negedge clk);
        do_start(100, 25, 0, 1'b1);
        wait_drain("drain_gate100");

        // Zero-length window.
        osc_period = 0;
        osc = 1'b0;
        repeat (5) @(negedge clk);
        do_start(0, 0, 0, 1'b1);
        check("gate0_busy_first", int'(busy), 1);
        @(negedge clk);
        check("gate0_busy_second", int'(busy), 0);
        wait_drain("drain_gate0");

        // 4-bit counter saturates: 20 edges in 40 cycles.
        osc_period = 2;
        repeat (10) @(negedge clk);
        begin
            exp_t e;
            e.count = 15;
            e.ovf   = 1;
            e.cyc   = cyc + 41;
            q_small.push_back(e);
        end
        gate_s  = 16'd40;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        wait_drain("drain_saturate");

        // Restart attempt during a window is ignored.
        osc_period = 5;
        repeat (10) @(negedge clk);
        do_start(50, 10, 0, 1'b1);
        repeat (9) @(negedge clk);
        gate  = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain("drain_restart_ignored");
        repeat (20) @(negedge clk);

        // Reset in the middle of a window aborts it silently.
        osc_period = 4;
        repeat (10) @(negedge clk);
        do_start(100, 0, 0, 1'b0);
        repeat (19) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_count", int'(count), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_overflow", int'(ovf), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (120) @(negedge clk);
        do_start(100, 25, 0, 1'b1);
        wait_drain("drain_after_abort");

        // osc high across reset release must not leak an edge into the window.
        osc_period = 0;
        osc = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        do_start(10, 0, 0, 1'b1);
        wait_drain("drain_osc_high_reset");

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/osc_edge_counter.md
OSC_EDGE_COUNTER -- requirements
Module: osc_edge_counter

Interface
REQ-001 SHALL have parameter COUNT_W, default 16: width of the edge-count result.
REQ-002 SHALL have parameter GATE_W, default 16: width of the gate-length input.
REQ-003 SHALL have parameter SYNC_STAGES, default 2 (legal 2..4): synchroniser depth on osc_i.
REQ-004 SHALL have port wb_clk_i, input, 1: the single clock; all flops on its rising edge.
REQ-005 SHALL have port wb_rst_n_i, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port osc_i, input, 1: asynchronous instrumented-adder output bit under measurement.
REQ-007 SHALL have port start_i, input, 1: one-cycle measurement request.
REQ-008 SHALL have port gate_i, input, GATE_W: window length in wb_clk_i cycles, sampled on accepted start.
REQ-009 SHALL have port count_o, output, COUNT_W: rising edges counted in the last window.
REQ-010 SHALL have port busy_o, output, 1: high while a measurement is in progress.
REQ-011 SHALL have port done_o, output, 1: one-cycle pulse, result valid.
REQ-012 SHALL have port overflow_o, output, 1: count saturated in the last window.

Function
REQ-013 SHALL pass osc_i through a SYNC_STAGES flop synchroniser, then a rising-edge detector (sync=1, previous=0); edge pulse is 1 cycle.
REQ-014 SHALL run the synchroniser and edge detector continuously, independent of FSM state.
REQ-015 SHALL implement FSM states IDLE, COUNT, DONE.
REQ-016 IDLE: start_i=1 -> latch gate_i into gate counter, clear count and overflow, go COUNT (gate_i!=0) or DONE (gate_i==0).
REQ-017 COUNT: every cycle add edge pulse to count, decrement gate counter; when gate counter reaches 1 at the clock edge, go DONE; exactly gate_i cycles sampled.
REQ-018 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-019 busy_o SHALL be 1 in COUNT and DONE, 0 in IDLE.
REQ-020 start_i while busy_o=1 SHALL be ignored (no restart, no latch of gate_i).
REQ-021 Count SHALL saturate at 2^COUNT_W-1; an edge arriving at saturation sets overflow_o; no wrap.
REQ-022 count_o and overflow_o SHALL update live during COUNT and hold their value from DONE until the next accepted start.
REQ-023 Latency: start accepted at cycle N -> COUNT cycles N+1..N+G -> done_o at N+G+1; gate 0 -> done_o at N+1, count 0.
REQ-024 Edges from osc_i appear in the count SYNC_STAGES+1 cycles after the pad transition; no compensation applied.

Reset
REQ-025 wb_rst_n_i low SHALL asynchronously force: FSM IDLE, count_o 0, overflow_o 0, busy_o 0, done_o 0, gate counter 0, all synchroniser/edge flops 0.
REQ-026 Reset asserted mid-COUNT SHALL abort the measurement with no done_o pulse; after release, block idles until a new start_i.
REQ-027 Reset release SHALL be synchronised externally; block assumes deassertion clean to wb_clk_i.

Structure
REQ-028 Package osc_meas_pkg SHALL hold the FSM state enum and default COUNT_W/GATE_W/SYNC_STAGES constants.
REQ-029 Sub-module edge_sync SHALL contain the synchroniser and rising-edge detector (ports wb_clk_i, wb_rst_n_i, async_i, edge_o).
REQ-030 Top-level SHALL contain FSM, gate counter, saturating counter only; no tristates (handled by the project wrapper).

Verification
REQ-031 osc_i rising every 4 clocks, gate_i=100, start -> done_o at start+101, count_o=25, overflow_o=0.
REQ-032 gate_i=0, start -> done_o next cycle, count_o=0, busy_o high for exactly 1 cycle.
REQ-033 COUNT_W=4, osc_i rising every 2 clocks, gate_i=40 -> count_o=15, overflow_o=1.
REQ-034 Second start_i pulse 10 cycles into a gate_i=50 window -> ignored; single done_o at first start+51.
REQ-035 wb_rst_n_i low 20 cycles into gate_i=100 window -> all outputs 0 immediately, no done_o; new start gives correct count.
REQ-036 osc_i held 1 through reset release -> no spurious edge counted in first window.
